// File: rtl/event_credit_tracker.sv
// Credit pool bookkeeping for the event buffer: acks return credits, granted starts spend them,
// and completed events are counted. All outputs are registered on memclk.
module event_credit_tracker #(
    parameter int NUM_BUFFERS = 4096,
    parameter int INIT_CYCLES = 16
) (
    input  logic        memclk,
    input  logic        rst_i,
    input  logic [11:0] ack_tdata,
    input  logic        ack_tvalid,
    output logic        ack_tready,
    input  logic        evt_start_i,
    output logic        evt_grant_o,
    output logic [11:0] evt_addr_o,
    input  logic        evt_done_i,
    output logic        allow_o,
    output logic [12:0] allow_count_o,
    output logic [13:0] cmpl_count_o,
    output logic [3:0]  err_o
);

    localparam int              INIT_W    = $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [12:0]     FULL      = 13'(NUM_BUFFERS);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    logic [INIT_W-1:0]   r_initCnt;
    logic                r_ackReady;
    logic                r_grant;
    logic                r_allow;
    logic [11:0]         r_evtAddr;
    logic [11:0]         r_wrPtr;
    logic [11:0]         r_ackPtr;
    logic [12:0]         r_credits;
    logic [12:0]         r_outstanding;
    logic [13:0]         r_cmplCount;
    logic [3:0]          r_err;

    logic                w_run;
    logic                w_initDone;
    logic                w_runNext;
    logic                w_ackAccept;
    logic                w_startOk;
    logic                w_startDenied;
    logic                w_ackOverflow;
    logic                w_ackOrder;
    logic                w_doneOk;
    logic                w_doneUnder;
    logic [12:0]         w_creditsNext;
    logic [12:0]         w_outstandingNext;

    assign w_run         = (r_state == ST_RUN);
    assign w_initDone    = (r_state == ST_INIT) && (r_initCnt == INIT_LAST);
    assign w_runNext     = w_run || w_initDone;
    assign w_ackAccept   = ack_tvalid && r_ackReady;
    assign w_startOk     = w_run && evt_start_i && (r_credits != 13'd0);
    assign w_startDenied = w_run && evt_start_i && (r_credits == 13'd0);
    assign w_ackOverflow = w_ackAccept && !w_startOk && (r_credits == FULL);
    assign w_ackOrder    = w_ackAccept && (ack_tdata != r_ackPtr);
    assign w_doneOk      = w_run && evt_done_i && (r_outstanding != 13'd0);
    assign w_doneUnder   = w_run && evt_done_i && (r_outstanding == 13'd0);

    // A simultaneous ack and granted start cancel; a lone ack at a full pool saturates.
    always_comb begin
        w_creditsNext = r_credits;
        if (w_ackAccept && !w_startOk && !w_ackOverflow)
            w_creditsNext = r_credits + 13'd1;
        else if (!w_ackAccept && w_startOk)
            w_creditsNext = r_credits - 13'd1;
    end

    always_comb begin
        w_outstandingNext = r_outstanding;
        if (w_startOk && !w_doneOk)
            w_outstandingNext = r_outstanding + 13'd1;
        else if (!w_startOk && w_doneOk)
            w_outstandingNext = r_outstanding - 13'd1;
    end

    always_ff @(posedge memclk) begin
        if (rst_i) begin
            r_state       <= ST_INIT;
            r_initCnt     <= '0;
            r_ackReady    <= 1'b0;
            r_grant       <= 1'b0;
            r_allow       <= 1'b0;
            r_evtAddr     <= 12'd0;
            r_wrPtr       <= 12'd0;
            r_ackPtr      <= 12'd0;
            r_credits     <= FULL;
            r_outstanding <= 13'd0;
            r_cmplCount   <= 14'd0;
            r_err         <= 4'd0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_initCnt <= r_initCnt + 1'b1;
                    if (w_initDone)
                        r_state <= ST_RUN;
                end
                ST_RUN: r_state <= ST_RUN;
                default: r_state <= ST_INIT;
            endcase

            r_ackReady    <= w_runNext;
            r_allow       <= w_runNext && (w_creditsNext != 13'd0);
            r_credits     <= w_creditsNext;
            r_outstanding <= w_outstandingNext;
            r_grant       <= w_startOk;

            if (w_startOk) begin
                r_evtAddr <= r_wrPtr;
                r_wrPtr   <= r_wrPtr + 12'd1;
            end
            if (w_ackAccept)
                r_ackPtr <= r_ackPtr + 12'd1;
            if (w_doneOk)
                r_cmplCount <= r_cmplCount + 14'd1;

            r_err <= r_err | {w_doneUnder, w_startDenied, w_ackOrder, w_ackOverflow};
        end
    end

    assign ack_tready    = r_ackReady;
    assign evt_grant_o   = r_grant;
    assign evt_addr_o    = r_evtAddr;
    assign allow_o       = r_allow;
    assign allow_count_o = r_credits;
    assign cmpl_count_o  = r_cmplCount;
    assign err_o         = r_err;

endmodule

// File: tb/tb_event_credit_tracker.sv
// Directed bench for event_credit_tracker: grants are scoreboarded by a negedge monitor,
// status outputs are compared against hand-computed values.
module tb_event_credit_tracker;

    logic        memclk = 1'b0;
    logic        rst_i;
    logic [11:0] ack_tdata;
    logic        ack_tvalid;
    logic        ack_tready;
    logic        evt_start_i;
    logic        evt_grant_o;
    logic [11:0] evt_addr_o;
    logic        evt_done_i;
    logic        allow_o;
    logic [12:0] allow_count_o;
    logic [13:0] cmpl_count_o;
    logic [3:0]  err_o;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] expAddrQ[$];
    logic [11:0] ackPtr;

    always #5 memclk = ~memclk;

    event_credit_tracker #(.NUM_BUFFERS(4096), .INIT_CYCLES(16)) dut (
        .memclk        (memclk),
        .rst_i         (rst_i),
        .ack_tdata     (ack_tdata),
        .ack_tvalid    (ack_tvalid),
        .ack_tready    (ack_tready),
        .evt_start_i   (evt_start_i),
        .evt_grant_o   (evt_grant_o),
        .evt_addr_o    (evt_addr_o),
        .evt_done_i    (evt_done_i),
        .allow_o       (allow_o),
        .allow_count_o (allow_count_o),
        .cmpl_count_o  (cmpl_count_o),
        .err_o         (err_o)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge memclk);
        #1;
    endtask

    // One memclk cycle of stimulus; an expected grant address is queued for the monitor.
    task automatic applyStimulus(input bit start, input bit expectGrant, input logic [11:0] expAddr,
                                 input bit ackV, input bit done);
        evt_start_i = start;
        evt_done_i  = done;
        ack_tvalid  = ackV;
        ack_tdata   = ackPtr;
        if (expectGrant) expAddrQ.push_back(expAddr);
        if (ackV) ackPtr = ackPtr + 12'd1;
        tick();
        evt_start_i = 1'b0;
        evt_done_i  = 1'b0;
        ack_tvalid  = 1'b0;
    endtask

    task automatic applyAck(input logic [11:0] data);
        ack_tvalid = 1'b1;
        ack_tdata  = data;
        tick();
        ack_tvalid = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, int'(ack_tready), 0);
        checkOutput({tag, "_grant"}, int'(evt_grant_o), 0);
        checkOutput({tag, "_addr"}, int'(evt_addr_o), 0);
        checkOutput({tag, "_allow"}, int'(allow_o), 0);
        checkOutput({tag, "_count"}, int'(allow_count_o), 4096);
        checkOutput({tag, "_cmpl"}, int'(cmpl_count_o), 0);
        checkOutput({tag, "_err"}, int'(err_o), 0);
    endtask

    // Resets, then counts edges until ack_tready rises; optional noise checks INIT ignores inputs.
    task automatic resetAndRun(input bit noise);
        int n;
        rst_i = 1'b1;
        tick();
        tick();
        checkResetValues("reset");
        rst_i  = 1'b0;
        ackPtr = 12'd0;
        n = 0;
        for (int k = 0; k < 64; k++) begin
            if (noise && k < 3) begin
                evt_start_i = 1'b1;
                evt_done_i  = 1'b1;
                ack_tvalid  = 1'b1;
                ack_tdata   = 12'd5;
            end
            tick();
            evt_start_i = 1'b0;
            evt_done_i  = 1'b0;
            ack_tvalid  = 1'b0;
            n++;
            if (ack_tready) break;
        end
        checkOutput("init_cycles", n, 16);
        checkOutput("run_allow", int'(allow_o), 1);
        checkOutput("run_count", int'(allow_count_o), 4096);
        checkOutput("run_err", int'(err_o), 0);
    endtask

    always @(negedge memclk) begin
        if (evt_grant_o === 1'b1) begin
            if (expAddrQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_grant: actual addr=%0d required no grant", evt_addr_o);
            end else begin
                logic [11:0] e;
                e = expAddrQ.pop_front();
                checkOutput("grant_addr", int'(evt_addr_o), int'(e));
            end
        end
    end

    initial begin
        rst_i       = 1'b1;
        ack_tdata   = 12'd0;
        ack_tvalid  = 1'b0;
        evt_start_i = 1'b0;
        evt_done_i  = 1'b0;
        ackPtr      = 12'd0;

        // Reset, INIT with ignored inputs, then overflow and done-underflow in RUN.
        resetAndRun(1'b1);
        applyStimulus(1'b0, 1'b0, 12'd0, 1'b1, 1'b0);
        checkOutput("ovf_err", int'(err_o), 4'b0001);
        checkOutput("ovf_count", int'(allow_count_o), 4096);
        applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
        checkOutput("underflow_err", int'(err_o), 4'b1001);
        checkOutput("underflow_cmpl", int'(cmpl_count_o), 0);

        // Drain the whole pool, then one denied start.
        resetAndRun(1'b0);
        for (int i = 0; i < 4096; i++) begin
            applyStimulus(1'b1, 1'b1, 12'(i), 1'b0, 1'b0);
            if (i == 0) checkOutput("first_count", int'(allow_count_o), 4095);
        end
        checkOutput("drain_count", int'(allow_count_o), 0);
        checkOutput("drain_allow", int'(allow_o), 0);
        checkOutput("drain_err", int'(err_o), 0);
        applyStimulus(1'b1, 1'b0, 12'd0, 1'b0, 1'b0);
        tick();
        checkOutput("deny_err", int'(err_o), 4'b0100);
        checkOutput("deny_count", int'(allow_count_o), 0);

        // Acks refill from empty; an out-of-order ack still returns its credit.
        applyAck(12'd0);
        checkOutput("refill_allow", int'(allow_o), 1);
        applyAck(12'd1);
        applyAck(12'd2);
        checkOutput("refill_count", int'(allow_count_o), 3);
        applyAck(12'd7);
        checkOutput("order_err", int'(err_o), 4'b0110);
        checkOutput("order_count", int'(allow_count_o), 4);
        checkOutput("pending_grants_a", expAddrQ.size(), 0);

        // Build credits=10, outstanding=5, then start+ack+done on one cycle.
        resetAndRun(1'b0);
        for (int i = 0; i < 4086; i++) applyStimulus(1'b1, 1'b1, 12'(i), 1'b0, 1'b0);
        checkOutput("ten_count", int'(allow_count_o), 10);
        for (int i = 0; i < 4081; i++) applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
        checkOutput("five_cmpl", int'(cmpl_count_o), 4081);
        applyStimulus(1'b1, 1'b1, 12'd4086, 1'b1, 1'b1);
        checkOutput("combo_count", int'(allow_count_o), 10);
        checkOutput("combo_cmpl", int'(cmpl_count_o), 4082);
        checkOutput("combo_err", int'(err_o), 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
        checkOutput("outst_cmpl", int'(cmpl_count_o), 4087);
        checkOutput("outst_err", int'(err_o), 0);
        applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
        checkOutput("outst_underflow", int'(err_o), 4'b1000);
        checkOutput("pending_grants_b", expAddrQ.size(), 0);

        // Completion counter wrap with credits recycled by acks.
        resetAndRun(1'b0);
        for (int i = 0; i < 16384; i++) begin
            applyStimulus(1'b1, 1'b1, 12'(i % 4096), 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
            if (i == 16382) checkOutput("cmpl_max", int'(cmpl_count_o), 16383);
        end
        checkOutput("cmpl_wrap", int'(cmpl_count_o), 0);
        checkOutput("wrap_count", int'(allow_count_o), 4096);
        checkOutput("wrap_err", int'(err_o), 0);

        // Reset arriving with a start must squash the grant.
        evt_start_i = 1'b1;
        rst_i       = 1'b1;
        tick();
        evt_start_i = 1'b0;
        checkResetValues("midrst");
        rst_i = 1'b0;
        tick();
        tick();
        checkOutput("pending_grants_c", expAddrQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
